// File: rtl/stream_pkg.sv
// Shared defaults and sizing helpers for the stream framer.
package stream_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int IMG_W_DEF   = 128;
    localparam int IMG_H_DEF   = 128;
    localparam int FRAME_CNT_W = 16;

    // Counter width for a 0..n-1 range; a 1-wide range still needs one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_skid.sv
// Two-entry in-order buffer with a registered upstream ready.
// The head entry drives the output directly, so output data is a register.
module stream_skid #(
    parameter int W = 11
) (
    input  logic         Clk,
    input  logic         rst_n,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         push_ready,
    output logic         pop_valid,
    output logic [W-1:0] pop_data,
    input  logic         pop_ready
);

    logic [1:0]   count_reg, count_next;
    logic [W-1:0] head_reg, head_next;
    logic [W-1:0] skid_reg, skid_next;
    logic         ready_reg, ready_next;
    logic         accept, emit;

    // Next occupancy and entry movement; ready is precomputed from the next occupancy.
    always_comb begin
        accept     = push_valid && ready_reg;
        emit       = (count_reg != 2'd0) && pop_ready;
        count_next = count_reg + {1'b0, accept} - {1'b0, emit};
        head_next  = head_reg;
        skid_next  = skid_reg;
        if (accept && ((count_reg == 2'd0) || ((count_reg == 2'd1) && emit))) begin
            head_next = push_data;
        end else if (emit && (count_reg == 2'd2)) begin
            head_next = skid_reg;
        end
        if (accept && (count_reg == 2'd1) && !emit) begin
            skid_next = push_data;
        end
        ready_next = (count_next <= 2'd1);
    end

    // Buffer state; reset empties the buffer and drops ready.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 2'd0;
            head_reg  <= '0;
            skid_reg  <= '0;
            ready_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            head_reg  <= head_next;
            skid_reg  <= skid_next;
            ready_reg <= ready_next;
        end
    end

    assign push_ready = ready_reg;
    assign pop_valid  = (count_reg != 2'd0);
    assign pop_data   = head_reg;

endmodule

// File: rtl/stream_framer.sv
// Tags an incoming pixel stream with start-of-frame, end-of-line and
// end-of-frame markers, buffers it, and counts completed frames.
module stream_framer
    import stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF
) (
    input  logic                   Clk,
    input  logic                   rst_n,
    input  logic                   Valid_in,
    input  logic [DATA_W-1:0]      Data_in,
    output logic                   Ready_to_src,
    output logic                   Valid_out,
    output logic [DATA_W-1:0]      Data_out,
    output logic                   User_out,
    output logic                   Eol_out,
    output logic                   Last_out,
    input  logic                   Ready_from_IP,
    output logic [FRAME_CNT_W-1:0] Frame_cnt
);

    localparam int XW = cnt_w(IMG_W);
    localparam int YW = cnt_w(IMG_H);
    localparam int PW = DATA_W + 3;

    logic [XW-1:0]          x_reg;
    logic [YW-1:0]          y_reg;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg;
    logic                   accept;
    logic                   tag_user, tag_eol, tag_last;
    logic [PW-1:0]          pop_data;
    logic                   pop_valid;

    assign accept   = Valid_in && Ready_to_src;
    assign tag_user = (x_reg == '0) && (y_reg == '0);
    assign tag_eol  = (x_reg == XW'(IMG_W - 1));
    assign tag_last = tag_eol && (y_reg == YW'(IMG_H - 1));

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (accept) begin
            if (tag_eol) begin
                x_reg <= '0;
                y_reg <= tag_last ? '0 : y_reg + 1'b1;
            end else begin
                x_reg <= x_reg + 1'b1;
            end
        end
    end

    stream_skid #(.W(PW)) u_skid (
        .Clk        (Clk),
        .rst_n      (rst_n),
        .push_valid (Valid_in),
        .push_data  ({tag_user, tag_eol, tag_last, Data_in}),
        .push_ready (Ready_to_src),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ready  (Ready_from_IP)
    );

    // Count a frame when its last pixel leaves downstream.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (pop_valid && Ready_from_IP && pop_data[DATA_W]) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
    end

    // Tags are qualified by valid so an emptied buffer shows no stale markers.
    assign Valid_out = pop_valid;
    assign Data_out  = pop_data[DATA_W-1:0];
    assign User_out  = pop_valid && pop_data[DATA_W+2];
    assign Eol_out   = pop_valid && pop_data[DATA_W+1];
    assign Last_out  = pop_valid && pop_data[DATA_W];
    assign Frame_cnt = frame_cnt_reg;

endmodule
